// File: rtl/bht_scheduler_pkg.sv
// ============================================================
// Module  : bht_scheduler_pkg
// Brief   : Shared constants and counter helper for the BHT scheduler
// Revision: 1.0
// ============================================================
`default_nettype none

package bht_scheduler_pkg;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;
    localparam logic [1:0] c_CTR_RST = c_CTR_WNT;

    localparam int c_DEF_IDX_W      = 8;
    localparam int c_DEF_FIFO_DEPTH = 4;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        case (ctr)
            c_CTR_SNT: nxt = (taken == c_TRUE) ? c_CTR_WNT : c_CTR_SNT;
            c_CTR_WNT: nxt = (taken == c_TRUE) ? c_CTR_WT  : c_CTR_SNT;
            c_CTR_WT:  nxt = (taken == c_TRUE) ? c_CTR_ST  : c_CTR_WNT;
            default:   nxt = (taken == c_TRUE) ? c_CTR_ST  : c_CTR_WT;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_update_fifo.sv
// ============================================================
// Module  : bht_update_fifo
// Brief   : Synchronous FIFO buffering committed branch updates
// Revision: 1.0
// ============================================================
`default_nettype none

module bht_update_fifo
    import bht_scheduler_pkg::*;
#(
    parameter int WIDTH = c_DEF_IDX_W + 1,
    parameter int DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bht_scheduler.sv
// ============================================================
// Module  : bht_scheduler
// Brief   : 2-bit BHT sharing one port between lookups and ROB updates
// Revision: 1.0
// ============================================================
`default_nettype none

module bht_scheduler
    import bht_scheduler_pkg::*;
#(
    parameter int IDX_W      = c_DEF_IDX_W,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
    input  logic                          lk_req,
    input  logic [IDX_W-1:0]              lk_idx,
    output logic                          lk_grant,
    output logic                          pred_valid,
    output logic                          pred_taken,
    output logic [IDX_W-1:0]              pred_idx,
    input  logic                          upd_valid,
    input  logic [IDX_W-1:0]              upd_idx,
    input  logic                          upd_taken,
    output logic                          upd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ENTRIES = 2 ** IDX_W;

    logic [1:0]       r_table [c_ENTRIES];
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drain;
    logic [IDX_W:0]   w_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;

    // Lookups win the port unless the FIFO is full; the drain gets the leftovers.
    assign lk_grant     = rdy & lk_req & ~w_full & ~flush;
    assign upd_ready    = rdy & ~w_full;
    assign w_push       = upd_valid & upd_ready;
    assign w_drain      = rdy & ~w_empty & ~lk_grant;
    assign w_head_idx   = w_head[IDX_W:1];
    assign w_head_taken = w_head[0];

    bht_update_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_drain),
        .din   ({upd_idx, upd_taken}),
        .dout  (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= c_CTR_RST;
            end
        end else if (w_drain) begin
            r_table[w_head_idx] <= ctr_next(r_table[w_head_idx], w_head_taken);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pred_valid <= c_FALSE;
            r_pred_taken <= c_FALSE;
            r_pred_idx   <= '0;
        end else if (rdy) begin
            r_pred_valid <= lk_grant;
            if (lk_grant) begin
                r_pred_taken <= r_table[lk_idx][1];
                r_pred_idx   <= lk_idx;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_idx   = r_pred_idx;

endmodule

`default_nettype wire

// File: tb/tb_bht_scheduler.sv
// ============================================================
// Module  : tb_bht_scheduler
// Brief   : Directed vector bench for bht_scheduler
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_bht_scheduler;

    typedef struct {
        logic       rdy;
        logic       flush;
        logic       lk_req;
        logic [7:0] lk_idx;
        logic       upd_valid;
        logic [7:0] upd_idx;
        logic       upd_taken;
        logic       e_grant;
        logic       e_ready;
        logic       e_pv;
        logic       e_pt;
        logic [7:0] e_pidx;
        logic [2:0] e_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic       lk_req;
    logic [7:0] lk_idx;
    logic       lk_grant;
    logic       pred_valid;
    logic       pred_taken;
    logic [7:0] pred_idx;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic [2:0] fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    bht_scheduler #(
        .IDX_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .lk_req     (lk_req),
        .lk_idx     (lk_idx),
        .lk_grant   (lk_grant),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .fifo_count (fifo_count)
    );

    function automatic vec_t mk(input logic r, input logic f, input logic lr, input logic [7:0] li,
                                input logic uv, input logic [7:0] ui, input logic ut,
                                input logic eg, input logic er, input logic epv, input logic ept,
                                input logic [7:0] epi, input logic [2:0] ec);
        vec_t v;
        v.rdy = r; v.flush = f; v.lk_req = lr; v.lk_idx = li;
        v.upd_valid = uv; v.upd_idx = ui; v.upd_taken = ut;
        v.e_grant = eg; v.e_ready = er; v.e_pv = epv; v.e_pt = ept;
        v.e_pidx = epi; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; comb outputs checked before the rising edge,
    // registered outputs checked just after it.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        rdy = v.rdy; flush = v.flush; lk_req = v.lk_req; lk_idx = v.lk_idx;
        upd_valid = v.upd_valid; upd_idx = v.upd_idx; upd_taken = v.upd_taken;
        #1;
        chk({tag, " lk_grant"}, 32'(lk_grant), 32'(v.e_grant));
        chk({tag, " upd_ready"}, 32'(upd_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        chk({tag, " pred_valid"}, 32'(pred_valid), 32'(v.e_pv));
        chk({tag, " fifo_count"}, 32'(fifo_count), 32'(v.e_cnt));
        if (v.e_pv) begin
            chk({tag, " pred_taken"}, 32'(pred_taken), 32'(v.e_pt));
            chk({tag, " pred_idx"}, 32'(pred_idx), 32'(v.e_pidx));
        end
    endtask

    initial begin
        //        rdy fl lk idx    uv idx    ut  grant rdy pv pt pidx  cnt
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 1, 8'h05, 0, 8'h00, 0, 1, 1, 1, 0, 8'h05, 0));
        // Two taken updates to idx 5: 01 -> 10 -> 11
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h05, 1, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h05, 1, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, 0, 1, 8'h05, 0, 8'h00, 0, 1, 1, 1, 1, 8'h05, 0));
        // Continuous lookups while four not-taken updates fill the FIFO
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk(1, 0, 1, 8'h07, 1, 8'h3F, 0, 1, 1, 1, 0, 8'h07, 3'(i)));
        vq.push_back(mk(1, 0, 1, 8'h07, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 3));
        vq.push_back(mk(1, 0, 1, 8'h07, 0, 8'h00, 0, 1, 1, 1, 0, 8'h07, 3));
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h3F, 0, 0, 1, 0, 0, 8'h00, 3));
        for (int i = 2; i >= 0; i--)
            vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 3'(i)));
        vq.push_back(mk(1, 0, 1, 8'h3F, 0, 8'h00, 0, 1, 1, 1, 0, 8'h3F, 0));
        // Five taken updates to 0x3F saturate at 11
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h3F, 1, 0, 1, 0, 0, 8'h00, 1));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h3F, 1, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, 0, 1, 8'h3F, 0, 8'h00, 0, 1, 1, 1, 1, 8'h3F, 0));
        // One not-taken from saturated 11 must give 10, still predicting taken
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h3F, 0, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, 0, 1, 8'h3F, 0, 8'h00, 0, 1, 1, 1, 1, 8'h3F, 0));
        // Flush with two entries queued: lookup killed, both entries still drain
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 8'h09, 1, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 1, 8'h09, 1, 8'h09, 1, 1, 1, 1, 0, 8'h09, 2));
        vq.push_back(mk(1, 1, 1, 8'h09, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        vq.push_back(mk(1, 0, 1, 8'h09, 0, 8'h00, 0, 1, 1, 1, 1, 8'h09, 0));

        rst = 1'b0; rdy = 1'b1; flush = 1'b0; lk_req = 1'b0; lk_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        #1;
        chk("reset pred_valid", 32'(pred_valid), 32'd0);
        chk("reset pred_taken", 32'(pred_taken), 32'd0);
        chk("reset pred_idx", 32'(pred_idx), 32'd0);
        chk("reset fifo_count", 32'(fifo_count), 32'd0);
        chk("reset upd_ready", 32'(upd_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

        // rdy low for three cycles with two updates pending and pred_valid high
        apply("rdy_a", mk(1, 0, 1, 8'h20, 1, 8'h20, 1, 1, 1, 1, 0, 8'h20, 1));
        apply("rdy_b", mk(1, 0, 1, 8'h05, 1, 8'h20, 1, 1, 1, 1, 1, 8'h05, 2));
        for (int i = 0; i < 3; i++)
            apply($sformatf("rdy_hold%0d", i), mk(0, 0, 1, 8'h20, 1, 8'h20, 0, 0, 0, 1, 1, 8'h05, 2));
        apply("rdy_res0", mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
        apply("rdy_res1", mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
        apply("rdy_look", mk(1, 0, 1, 8'h20, 0, 8'h00, 0, 1, 1, 1, 1, 8'h20, 0));

        // Asynchronous reset mid-operation discards the queued update and the prediction
        apply("mr_pre", mk(1, 0, 1, 8'h05, 1, 8'h05, 1, 1, 1, 1, 1, 8'h05, 1));
        @(negedge clk);
        lk_req = 1'b0; upd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midreset pred_valid", 32'(pred_valid), 32'd0);
        chk("midreset pred_idx", 32'(pred_idx), 32'd0);
        chk("midreset fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply("mr_look", mk(1, 0, 1, 8'h05, 0, 8'h00, 0, 1, 1, 1, 0, 8'h05, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bht_scheduler.md
# bht_scheduler

Branch-history-table scheduler that owns a table of 2-bit saturating counters and shares its single access port between fetch-side prediction lookups and ROB-side commit updates. It sits between IF/predictor (lookup) and ROB (resolved-branch feedback). ROB updates are buffered in a small FIFO and drained into the table whenever the port is free. A flush kills any in-flight lookup but never discards committed updates.

## Interface

Parameters:
- IDX_W, 8 — table index width; the table holds 2^IDX_W counters.
- FIFO_DEPTH, 4 — update FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  — system clock; all state changes on its rising edge.
- rst  in  1  — asynchronous, active-low reset.
- rdy  in  1  — global enable; when low, no register changes.
- flush  in  1  — mispredict/redirect from ROB (jump_wrong).
- lk_req  in  1  — IF requests a prediction.
- lk_idx  in  IDX_W  — PC-derived table index.
- lk_grant  out  1  — combinational; the lookup is accepted this cycle.
- pred_valid  out  1  — registered; the prediction result is valid.
- pred_taken  out  1  — registered; predicted direction (counter MSB).
- pred_idx  out  IDX_W  — registered; index the result belongs to.
- upd_valid  in  1  — ROB commits a resolved conditional branch.
- upd_idx  in  IDX_W  — index of the committed branch.
- upd_taken  in  1  — actual outcome.
- upd_ready  out  1  — combinational; FIFO can accept an update.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  — registered occupancy.

## Operation

- Table: 2^IDX_W entries, 2 bits each. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Exactly one table operation per cycle: either a read (lookup) or a read-modify-write (drain).

Port arbitration, per cycle with rdy=1:
- full = (fifo_count == FIFO_DEPTH).
- lk_grant = lk_req & !full & !flush.
- drain = (fifo_count != 0) & !lk_grant.
- Lookup wins unless the FIFO is full. When full, the drain has priority and IF must hold lk_req/lk_idx until granted.

Lookup:
- When granted, the read counter MSB is registered to pred_taken, lk_idx to pred_idx, and pred_valid is set to 1.
- Otherwise pred_valid is set to 0.

Update:
- upd_ready = !full. The push condition is upd_valid & upd_ready; a push while full is ignored (it is a ROB protocol violation).
- Drain pops the FIFO head {idx, taken}. The counter is incremented when taken and decremented when not taken, saturating at 11 and 00.
- Push and pop in the same cycle leave fifo_count unchanged; the pointers wrap modulo FIFO_DEPTH.
- Consecutive drains to the same index compound correctly, because each drain reads the value written on the previous edge.
- Lookups read the table only. Pending FIFO entries are not bypassed, so a stale prediction is architecturally acceptable.

Flush:
- lk_grant is forced to 0 during the flush cycle, so pred_valid is 0 on the following cycle.
- FIFO contents and draining are unaffected.

rdy=0:
- All registers hold, including pred_valid, the FIFO and the table.
- lk_grant = 0, upd_ready = 0.

## Timing

Reset (rst low, asynchronous):
- Every counter is set to 01.
- FIFO empty, fifo_count = 0.
- pred_valid = 0, pred_taken = 0, pred_idx = 0.
- Combinational outputs then evaluate as: upd_ready = 1 while rdy = 1, and lk_grant = lk_req while rdy = 1.

Cycle-level behaviour:
- Lookup latency: grant in cycle N gives pred_valid/pred_taken in N+1. pred_valid is a one-cycle pulse per grant; back-to-back grants give back-to-back results.
- Update latency: a push in cycle N makes the entry drainable in N+1. The earliest table write lands on the edge ending N+1.
- Full FIFO: the drain in cycle N frees a slot, so upd_ready rises in N+1. Lookups stall for exactly one cycle per drain needed to leave the full state.
- Reset mid-operation discards pending updates and any in-flight prediction immediately.

## Structure

- Shared package/define file: TRUE/FALSE constants, counter encodings (SNT/WNT/WT/ST), counter reset value, and default IDX_W/FIFO_DEPTH.
- One sub-module: bht_update_fifo (synchronous FIFO with push/pop/count and async active-low reset, width IDX_W+1).
- Table, arbitration and saturating update logic stay in bht_scheduler.

## Test plan

- Reset, then lk_req on idx 5 every cycle → lk_grant=1 each cycle; pred_valid=1 and pred_taken=0 each following cycle; fifo_count=0.
- Push 2 taken updates to idx 5 with lk_req idle → drains in the next two cycles; counter goes 01→10→11; a following lookup gives pred_taken=1.
- Hold lk_req=1 continuously and push 4 updates → FIFO fills (fifo_count=4, upd_ready=0); lk_grant drops for one drain cycle; fifo_count returns to 3; upd_ready=1 the next cycle.
- Saturation: 5 not-taken updates to idx 0x3F → counter stays 00; 5 taken updates → counter stays 11.
- Assert flush in the same cycle as lk_req with the FIFO holding 2 entries → lk_grant=0; pred_valid=0 next cycle; both entries still drain over the following 2 cycles.
- Set rdy=0 for 3 cycles mid-drain with pred_valid=1 → all outputs hold, fifo_count is unchanged, lk_grant=0, upd_ready=0; operation resumes on the first cycle with rdy=1.
